vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, sync/blank decode and
// a registered pixel stage with external, colour-bar, checker and gradient sources.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 8
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic [11:0]        x,
    output logic [11:0]        y,
    output logic               blank_n,
    output logic               HS,
    output logic               VS,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned CMP_W   = CNT_W + 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] BAR_W  = CNT_W'(H_ACTIVE / 8);

    // Window bounds carry one extra bit so an end value of 4096 does not alias to 0.
    localparam logic [CMP_W-1:0] H_ACT  = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_ACT  = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] HS_BEG = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] HS_END = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] VS_BEG = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] VS_END = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 4096) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL must not exceed 4096");
    end
    if (V_TOTAL > 4096) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL must not exceed 4096");
    end
    if (H_ACTIVE < 8) begin : g_h_active_chk
        $error("vga_timing_gen: H_ACTIVE must be at least 8");
    end

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    logic [1:0]         mode_q;
    logic               h_last;
    logic               v_last;
    logic               active;
    logic               hs_win;
    logic               vs_win;
    logic [CNT_W-1:0]   bar_q;
    logic [2:0]         bar;
    logic               blank_n_nxt;
    logic               hs_nxt;
    logic               vs_nxt;
    logic               ls_nxt;
    logic               fs_nxt;
    logic [COLOR_W-1:0] r_nxt;
    logic [COLOR_W-1:0] g_nxt;
    logic [COLOR_W-1:0] b_nxt;

    assign x      = h_cnt;
    assign y      = v_cnt;
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Raster counters; the pattern mode is only picked up on a frame wrap.
    always_ff @(posedge vga_clk or negedge reset_n) begin : p_cnt
        if (!reset_n) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            mode_q <= mode;
        end else if (en) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt  <= '0;
                    mode_q <= mode;
                end else begin
                    v_cnt <= v_cnt + CNT_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Decode of the current position into the values registered on the next edge.
    always_comb begin : p_decode
        active      = ({1'b0, h_cnt} < H_ACT) && ({1'b0, v_cnt} < V_ACT);
        hs_win      = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
        vs_win      = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
        bar_q       = h_cnt / BAR_W;
        bar         = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
        blank_n_nxt = 1'b0;
        hs_nxt      = ~HS_POL;
        vs_nxt      = ~VS_POL;
        ls_nxt      = 1'b0;
        fs_nxt      = 1'b0;
        r_nxt       = '0;
        g_nxt       = '0;
        b_nxt       = '0;
        if (en) begin
            blank_n_nxt = active;
            hs_nxt      = hs_win ? HS_POL : ~HS_POL;
            vs_nxt      = vs_win ? VS_POL : ~VS_POL;
            ls_nxt      = (h_cnt == '0);
            fs_nxt      = (h_cnt == '0) && (v_cnt == '0);
            if (active) begin
                unique case (mode_q)
                    2'b00: begin
                        r_nxt = pix_r;
                        g_nxt = pix_g;
                        b_nxt = pix_b;
                    end
                    2'b01: begin
                        r_nxt = {COLOR_W{bar[2]}};
                        g_nxt = {COLOR_W{bar[1]}};
                        b_nxt = {COLOR_W{bar[0]}};
                    end
                    2'b10: begin
                        r_nxt = {COLOR_W{h_cnt[5] ^ v_cnt[5]}};
                        g_nxt = {COLOR_W{h_cnt[5] ^ v_cnt[5]}};
                        b_nxt = {COLOR_W{h_cnt[5] ^ v_cnt[5]}};
                    end
                    default: begin
                        r_nxt = COLOR_W'(h_cnt);
                        g_nxt = COLOR_W'(v_cnt);
                    end
                endcase
            end
        end
    end

    // Output stage: everything lags the counters by exactly one clock.
    always_ff @(posedge vga_clk or negedge reset_n) begin : p_out
        if (!reset_n) begin
            blank_n     <= 1'b0;
            HS          <= ~HS_POL;
            VS          <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            blank_n     <= blank_n_nxt;
            HS          <= hs_nxt;
            VS          <= vs_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
            red         <= r_nxt;
            green       <= g_nxt;
            blue        <= b_nxt;
        end
    end

endmodule
